fb_fill_scheduler: RTL and testbench
====================================

# fb_fill_scheduler

Sequences full-screen framebuffer writes for the display pipeline. The block raster-scans every pixel, holding one color per pass, and shares the single framebuffer write port between two requesters: the automatic post-reset clear and the user fill command (button-driven). Pixel writes use a valid/ready handshake with the framebuffer, and each pass reports completion with a one-cycle done pulse.

## Interface
- H_RES, 640, pixels per line
- V_RES, 480, lines per frame
- COLOR_W, 12, pixel color width
- CLEAR_COLOR, 0, color written by a clear pass
- X_W, $clog2(H_RES), x address width (derived)
- Y_W, $clog2(V_RES), y address width (derived)

- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- req_clear  in  1  request clear pass (level or pulse; sampled per cycle)
- req_fill  in  1  request fill pass with fill_color
- fill_color  in  COLOR_W  color captured when req_fill is sampled high
- abort  in  1  terminate current pass; no done
- fb_ready  in  1  framebuffer accepts write this cycle
- pix_we  out  1  write valid
- pix_x  out  X_W  column of current write
- pix_y  out  Y_W  row of current write
- pix_color  out  COLOR_W  color of current write
- busy  out  1  pass in progress (CLEAR or FILL state)
- done  out  1  one-cycle pulse after final pixel accepted
- active_src  out  1  0 = clear pass, 1 = fill pass; valid while busy

## Operation
- States: IDLE, CLEAR, FILL, DONE.
- Pending flags pend_clear and pend_fill, one deep. A request sets its flag in any state. pend_fill also captures fill_color into fill_latch; a later req_fill before service overwrites the color. Repeated requests never queue more than one pass per source.
- Reset sets pend_clear=1, so a clear pass starts automatically after reset.
- IDLE: pend_clear wins over pend_fill (fixed priority). On grant, clear the selected flag, load x=0, y=0 and the pass color (CLEAR_COLOR or fill_latch), and enter CLEAR/FILL.
- CLEAR/FILL: pix_we=1. A write transfers only when pix_we && fb_ready. On transfer:
  - If x<H_RES-1: x++.
  - Else: x=0 and y++.
  - At x=H_RES-1 and y=V_RES-1: go to DONE.
- Without fb_ready, x, y and color hold (no skipped or duplicated pixels).
- DONE: done=1 for exactly one cycle, then IDLE. Arbitration runs in IDLE, so back-to-back passes have one IDLE cycle between them.
- abort in CLEAR/FILL: next state IDLE, pix_we drops next cycle, no done. The pixel transferring in the abort cycle counts as written. Pending flags are untouched. abort in IDLE/DONE is ignored.
- A request for the source currently running sets its pending flag, so that pass repeats afterward.
- pix_color is constant for a whole pass. A fill_color change mid-pass affects only the next fill.
- Counters are unsigned with explicit wrap compares; no reliance on power-of-two overflow.

## Timing
- Reset values: pix_we=0, pix_x=0, pix_y=0, pix_color=0, busy=0, done=0, active_src=0, state=IDLE, pend_fill=0, pend_clear=1.
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- Request latency: request high in cycle N sets pending at N+1. If IDLE at N+1, busy and pix_we are high at N+2 with pixel (0,0).
- Zero-stall pass length is H_RES*V_RES write cycles. DONE follows the final transfer by 1 cycle; IDLE follows 1 cycle after that.
- reset asserted mid-pass: state is IDLE next edge, all outputs at reset values, and the auto clear is re-armed.
- Simultaneous req_clear and req_fill: both flags are set; clear runs first, then fill.

## Structure
- Shared package fb_pkg: state enum fb_sched_state_t {IDLE, CLEAR, FILL, DONE}, source encoding SRC_CLEAR=0/SRC_FILL=1, and default resolution/color-width constants shared with the VGA timing and framebuffer blocks.
- One sub-module, fb_scan_counter: the x/y raster counter with advance enable, load-zero, and last-pixel flag. The scheduler owns the state machine, pending flags, arbitration and color muxing.

## Test plan
Use H_RES=4, V_RES=3, COLOR_W=4.
- Reset released, fb_ready=1 → auto clear: 12 writes (0,0)…(3,2) with color 0, done pulse the cycle after (3,2), busy low afterward.
- req_fill with fill_color=4'hA in IDLE → pix_we at N+2; 12 writes of color A, active_src=1, one done.
- fb_ready toggled 1,0,0,1… during fill → every address is written exactly once and in order, and the address holds during stalls.
- req_clear and req_fill (color 5) in the same cycle → full clear pass, done, one IDLE cycle, full fill pass of color 5, two done pulses total.
- abort at pixel (2,1) of a fill, with req_fill (color 3) pending → no done; the next pass restarts at (0,0) with color 3.
- reset pulsed at pixel (1,1) of a fill → outputs at reset values next cycle, then a fresh clear pass from (0,0).

Source files
------------

// File: rtl/fb_pkg.sv
// Shared framebuffer definitions.
// The VGA timing, framebuffer and fill scheduler blocks use these.
//   fb_sched_state_t : fill scheduler state encoding
//   SRC_CLEAR/SRC_FILL : active_src encoding
//   FB_H_RES/FB_V_RES/FB_COLOR_W : default resolution and color width
package fb_pkg;

  localparam int unsigned FB_H_RES   = 640;
  localparam int unsigned FB_V_RES   = 480;
  localparam int unsigned FB_COLOR_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } fb_sched_state_t;

  localparam logic SRC_CLEAR = 1'b0;
  localparam logic SRC_FILL  = 1'b1;

endpackage

// File: rtl/fb_fill_scheduler_if.sv
// Framebuffer pixel write port with a valid/ready handshake.
// A write transfers in any cycle where pix_we and fb_ready are both high.
//   pix_we    : write valid (master -> slave)
//   pix_x     : column of the write
//   pix_y     : row of the write
//   pix_color : pixel color
//   fb_ready  : framebuffer accepts the write this cycle (slave -> master)
interface fb_fill_scheduler_if
  import fb_pkg::*;
#(
  parameter int unsigned COLOR_W = FB_COLOR_W,
  parameter int unsigned X_W     = $clog2(FB_H_RES),
  parameter int unsigned Y_W     = $clog2(FB_V_RES)
);

  logic               pix_we;
  logic [X_W-1:0]     pix_x;
  logic [Y_W-1:0]     pix_y;
  logic [COLOR_W-1:0] pix_color;
  logic               fb_ready;

  modport master (
    output pix_we,
    output pix_x,
    output pix_y,
    output pix_color,
    input  fb_ready
  );

  modport slave (
    input  pix_we,
    input  pix_x,
    input  pix_y,
    input  pix_color,
    output fb_ready
  );

endinterface

// File: rtl/fb_scan_counter.sv
// Raster x/y counter for a full-screen pass.
//   clk       : system clock
//   reset     : synchronous active-high reset, clears x and y
//   load_zero : restart the scan at (0,0)
//   advance   : step to the next pixel in raster order
//   x, y      : current pixel address
//   last      : current pixel is (H_RES-1, V_RES-1)
module fb_scan_counter
  import fb_pkg::*;
#(
  parameter int unsigned H_RES = FB_H_RES,
  parameter int unsigned V_RES = FB_V_RES,
  parameter int unsigned X_W   = $clog2(H_RES),
  parameter int unsigned Y_W   = $clog2(V_RES)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load_zero,
  input  logic           advance,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

  // Wrap points are compared explicitly so non-power-of-two sizes work.
  always_ff @(posedge clk) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (load_zero) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x < X_LAST) begin
        x <= x + X_W'(1);
      end else begin
        x <= '0;
        if (y < Y_LAST) begin
          y <= y + Y_W'(1);
        end else begin
          y <= '0;
        end
      end
    end
  end

  assign last = (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/fb_fill_scheduler.sv
// Full-screen framebuffer fill scheduler.
// Arbitrates between the post-reset clear and the user fill command and
// raster-scans every pixel with one color per pass over the pix port.
//   clk, reset   : system clock, synchronous active-high reset
//   req_clear    : request a clear pass (sampled every cycle)
//   req_fill     : request a fill pass, fill_color captured with it
//   fill_color   : color for the requested fill
//   abort        : terminate the running pass without a done pulse
//   busy         : a pass is in progress
//   done         : one-cycle pulse after the final pixel is accepted
//   active_src   : 0 = clear pass, 1 = fill pass (valid while busy)
//   pix          : pixel write port (pix_we/pix_x/pix_y/pix_color, fb_ready)
module fb_fill_scheduler
  import fb_pkg::*;
#(
  parameter int unsigned        H_RES       = FB_H_RES,
  parameter int unsigned        V_RES       = FB_V_RES,
  parameter int unsigned        COLOR_W     = FB_COLOR_W,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0,
  parameter int unsigned        X_W         = $clog2(H_RES),
  parameter int unsigned        Y_W         = $clog2(V_RES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_clear,
  input  logic               req_fill,
  input  logic [COLOR_W-1:0] fill_color,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               active_src,
  fb_fill_scheduler_if.master pix
);

  fb_sched_state_t    state, state_next;
  logic               pend_clear, pend_fill;
  logic [COLOR_W-1:0] fill_latch;
  logic [COLOR_W-1:0] pass_color;
  logic               grant_clear, grant_fill;
  logic               load_zero;
  logic               xfer;
  logic               last_pix;
  logic [X_W-1:0]     scan_x;
  logic [Y_W-1:0]     scan_y;

  // Outputs are decoded from registered state only.
  assign busy = (state == CLEAR) || (state == FILL);
  assign done = (state == DONE);
  assign xfer = busy && pix.fb_ready;

  assign pix.pix_we    = busy;
  assign pix.pix_x     = scan_x;
  assign pix.pix_y     = scan_y;
  assign pix.pix_color = pass_color;

  fb_scan_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .X_W   (X_W),
    .Y_W   (Y_W)
  ) u_scan (
    .clk       (clk),
    .reset     (reset),
    .load_zero (load_zero),
    .advance   (xfer),
    .x         (scan_x),
    .y         (scan_y),
    .last      (last_pix)
  );

  always_comb begin
    state_next  = state;
    grant_clear = 1'b0;
    grant_fill  = 1'b0;
    load_zero   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend_clear) begin
          grant_clear = 1'b1;
          load_zero   = 1'b1;
          state_next  = CLEAR;
        end else if (pend_fill) begin
          grant_fill  = 1'b1;
          load_zero   = 1'b1;
          state_next  = FILL;
        end
      end
      CLEAR, FILL: begin
        // abort wins over a final transfer in the same cycle: no done.
        if (abort) begin
          state_next = IDLE;
        end else if (xfer && last_pix) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A request arriving in the grant cycle re-arms its flag, so the
  // same source runs again after the pass it was granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pend_clear <= 1'b1;
      pend_fill  <= 1'b0;
      fill_latch <= '0;
      pass_color <= '0;
      active_src <= SRC_CLEAR;
    end else begin
      state      <= state_next;
      pend_clear <= req_clear | (pend_clear & ~grant_clear);
      pend_fill  <= req_fill  | (pend_fill  & ~grant_fill);
      if (req_fill) begin
        fill_latch <= fill_color;
      end
      if (grant_clear) begin
        pass_color <= CLEAR_COLOR;
        active_src <= SRC_CLEAR;
      end else if (grant_fill) begin
        pass_color <= fill_latch;
        active_src <= SRC_FILL;
      end
    end
  end

endmodule

// File: tb/tb_fb_fill_scheduler.sv
// Directed bench for fb_fill_scheduler on a 4x3 screen with 4-bit color.
module tb_fb_fill_scheduler;
  import fb_pkg::*;

  localparam int unsigned H    = 4;
  localparam int unsigned V    = 3;
  localparam int unsigned CW   = 4;
  localparam int unsigned NPIX = H * V;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_clear;
  logic          req_fill;
  logic [CW-1:0] fill_color;
  logic          abort;
  logic          busy;
  logic          done;
  logic          active_src;
  logic [11:0]   obs;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fb_fill_scheduler_if #(.COLOR_W(CW), .X_W(2), .Y_W(2)) pix ();

  fb_fill_scheduler #(
    .H_RES       (H),
    .V_RES       (V),
    .COLOR_W     (CW),
    .CLEAR_COLOR (4'h0),
    .X_W         (2),
    .Y_W         (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_clear  (req_clear),
    .req_fill   (req_fill),
    .fill_color (fill_color),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .active_src (active_src),
    .pix        (pix.master)
  );

  // {pix_we, busy, done, active_src, x[1:0], y[1:0], color[3:0]}
  assign obs = {pix.pix_we, busy, done, active_src, pix.pix_x, pix.pix_y, pix.pix_color};

  function automatic logic [11:0] ev(input logic we, input logic b, input logic d,
                                     input logic s, input int unsigned p,
                                     input logic [3:0] c);
    ev = {we, b, d, s, 2'(p % H), 2'(p / H), c};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; req_clear = 1'b0; req_fill = 1'b0; abort = 1'b0;
    fill_color = '0; pix.fb_ready = 1'b1;
    step(); step();
    n_cmp++;
    if (obs !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_state: got %h want %h", obs, 12'h000);
    end
  endtask

  task automatic test_auto_clear();
    reset = 1'b0;
    step();
    for (int unsigned p = 0; p < NPIX; p++) begin
      n_cmp++;
      if (obs !== ev(1'b1, 1'b1, 1'b0, SRC_CLEAR, p, 4'h0)) begin
        n_bad++;
        $display("FAIL clear_pix[%0d]: got %h want %h", p, obs, ev(1'b1, 1'b1, 1'b0, SRC_CLEAR, p, 4'h0));
      end
      step();
    end
    n_cmp++;
    if (obs[11:9] !== 3'b001) begin
      n_bad++;
      $display("FAIL clear_done: got %b want 001", obs[11:9]);
    end
    step();
    n_cmp++;
    if (obs[11:9] !== 3'b000) begin
      n_bad++;
      $display("FAIL clear_idle: got %b want 000", obs[11:9]);
    end
  endtask

  task automatic test_fill();
    req_fill = 1'b1; fill_color = 4'hA;
    step();
    req_fill = 1'b0; fill_color = 4'h0;
    n_cmp++;
    if (obs[11:9] !== 3'b000) begin
      n_bad++;
      $display("FAIL fill_latency: got %b want 000", obs[11:9]);
    end
    step();
    for (int unsigned p = 0; p < NPIX; p++) begin
      n_cmp++;
      if (obs !== ev(1'b1, 1'b1, 1'b0, SRC_FILL, p, 4'hA)) begin
        n_bad++;
        $display("FAIL fill_pix[%0d]: got %h want %h", p, obs, ev(1'b1, 1'b1, 1'b0, SRC_FILL, p, 4'hA));
      end
      step();
    end
    n_cmp++;
    if (obs[11:9] !== 3'b001) begin
      n_bad++;
      $display("FAIL fill_done: got %b want 001", obs[11:9]);
    end
    step();
    n_cmp++;
    if (obs[11:9] !== 3'b000) begin
      n_bad++;
      $display("FAIL fill_idle: got %b want 000", obs[11:9]);
    end
  endtask

  task automatic test_stall();
    int unsigned idx = 0;
    int unsigned k = 0;
    logic rdy;
    req_fill = 1'b1; fill_color = 4'h6;
    step();
    req_fill = 1'b0;
    step();
    while (idx < NPIX && k < 60) begin
      n_cmp++;
      if (obs !== ev(1'b1, 1'b1, 1'b0, SRC_FILL, idx, 4'h6)) begin
        n_bad++;
        $display("FAIL stall_pix[%0d] cyc %0d: got %h want %h", idx, k, obs, ev(1'b1, 1'b1, 1'b0, SRC_FILL, idx, 4'h6));
      end
      rdy = (k % 3 == 0);
      pix.fb_ready = rdy;
      step();
      if (rdy) idx++;
      k++;
    end
    pix.fb_ready = 1'b1;
    n_cmp++;
    if (idx != NPIX) begin
      n_bad++;
      $display("FAIL stall_timeout: got %0d pixels want %0d", idx, NPIX);
    end
    n_cmp++;
    if (obs[11:9] !== 3'b001) begin
      n_bad++;
      $display("FAIL stall_done: got %b want 001", obs[11:9]);
    end
    step();
    n_cmp++;
    if (obs[11:9] !== 3'b000) begin
      n_bad++;
      $display("FAIL stall_idle: got %b want 000", obs[11:9]);
    end
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    req_clear = 1'b1; req_fill = 1'b1; fill_color = 4'h5;
    step();
    req_clear = 1'b0; req_fill = 1'b0; fill_color = 4'h0;
    step();
    for (int unsigned p = 0; p < NPIX; p++) begin
      n_cmp++;
      if (obs !== ev(1'b1, 1'b1, 1'b0, SRC_CLEAR, p, 4'h0)) begin
        n_bad++;
        $display("FAIL b2b_clear_pix[%0d]: got %h want %h", p, obs, ev(1'b1, 1'b1, 1'b0, SRC_CLEAR, p, 4'h0));
      end
      step();
    end
    if (done === 1'b1) ndone++;
    n_cmp++;
    if (obs[11:9] !== 3'b001) begin
      n_bad++;
      $display("FAIL b2b_clear_done: got %b want 001", obs[11:9]);
    end
    step();
    n_cmp++;
    if (obs[11:9] !== 3'b000) begin
      n_bad++;
      $display("FAIL b2b_gap_idle: got %b want 000", obs[11:9]);
    end
    step();
    for (int unsigned p = 0; p < NPIX; p++) begin
      n_cmp++;
      if (obs !== ev(1'b1, 1'b1, 1'b0, SRC_FILL, p, 4'h5)) begin
        n_bad++;
        $display("FAIL b2b_fill_pix[%0d]: got %h want %h", p, obs, ev(1'b1, 1'b1, 1'b0, SRC_FILL, p, 4'h5));
      end
      step();
    end
    if (done === 1'b1) ndone++;
    step();
    n_cmp++;
    if (obs[11:9] !== 3'b000) begin
      n_bad++;
      $display("FAIL b2b_idle: got %b want 000", obs[11:9]);
    end
    n_cmp++;
    if (ndone != 2) begin
      n_bad++;
      $display("FAIL b2b_done_count: got %0d want 2", ndone);
    end
  endtask

  task automatic test_abort();
    req_fill = 1'b1; fill_color = 4'h9;
    step();
    req_fill = 1'b0;
    step();
    for (int unsigned p = 0; p <= 6; p++) begin
      n_cmp++;
      if (obs !== ev(1'b1, 1'b1, 1'b0, SRC_FILL, p, 4'h9)) begin
        n_bad++;
        $display("FAIL abort_pix[%0d]: got %h want %h", p, obs, ev(1'b1, 1'b1, 1'b0, SRC_FILL, p, 4'h9));
      end
      if (p == 2) begin req_fill = 1'b1; fill_color = 4'h3; end
      if (p == 3) req_fill = 1'b0;
      if (p == 6) abort = 1'b1;
      step();
    end
    abort = 1'b0;
    n_cmp++;
    if (obs[11:9] !== 3'b000) begin
      n_bad++;
      $display("FAIL abort_idle: got %b want 000", obs[11:9]);
    end
    step();
    for (int unsigned p = 0; p < NPIX; p++) begin
      n_cmp++;
      if (obs !== ev(1'b1, 1'b1, 1'b0, SRC_FILL, p, 4'h3)) begin
        n_bad++;
        $display("FAIL abort_restart_pix[%0d]: got %h want %h", p, obs, ev(1'b1, 1'b1, 1'b0, SRC_FILL, p, 4'h3));
      end
      step();
    end
    n_cmp++;
    if (obs[11:9] !== 3'b001) begin
      n_bad++;
      $display("FAIL abort_restart_done: got %b want 001", obs[11:9]);
    end
    step();
  endtask

  task automatic test_reset_mid();
    req_fill = 1'b1; fill_color = 4'hC;
    step();
    req_fill = 1'b0;
    step();
    for (int unsigned p = 0; p <= 5; p++) begin
      n_cmp++;
      if (obs !== ev(1'b1, 1'b1, 1'b0, SRC_FILL, p, 4'hC)) begin
        n_bad++;
        $display("FAIL rmid_pix[%0d]: got %h want %h", p, obs, ev(1'b1, 1'b1, 1'b0, SRC_FILL, p, 4'hC));
      end
      if (p == 5) reset = 1'b1;
      step();
    end
    n_cmp++;
    if (obs !== 12'h000) begin
      n_bad++;
      $display("FAIL rmid_reset_state: got %h want %h", obs, 12'h000);
    end
    reset = 1'b0;
    step();
    for (int unsigned p = 0; p < NPIX; p++) begin
      n_cmp++;
      if (obs !== ev(1'b1, 1'b1, 1'b0, SRC_CLEAR, p, 4'h0)) begin
        n_bad++;
        $display("FAIL rmid_clear_pix[%0d]: got %h want %h", p, obs, ev(1'b1, 1'b1, 1'b0, SRC_CLEAR, p, 4'h0));
      end
      step();
    end
    n_cmp++;
    if (obs[11:9] !== 3'b001) begin
      n_bad++;
      $display("FAIL rmid_clear_done: got %b want 001", obs[11:9]);
    end
    step();
    step();
    n_cmp++;
    if (obs[11:9] !== 3'b000) begin
      n_bad++;
      $display("FAIL rmid_no_fill_after_reset: got %b want 000", obs[11:9]);
    end
  endtask

  initial begin
    test_reset();
    test_auto_clear();
    test_fill();
    test_stall();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
